// File: rtl/srio_target_responder_if.sv
// AXI-Stream channel bundle for the SRIO HELLO 64-bit treq/tresp ports.
interface srio_target_responder_if;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic [31:0] tuser;

  modport master (output tvalid, tlast, tdata, tkeep, tuser, input tready);
  modport slave  (input tvalid, tlast, tdata, tkeep, tuser, output tready);
endinterface

// File: rtl/srio_target_responder.sv
// SRIO target-side responder: stores writes in a word RAM, answers NREAD from it,
// acknowledges doorbells and messages, drops unsupported packets.
module srio_target_responder #(
  parameter int MEM_AW = 6
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  srio_target_responder_if.slave         s_axis_treq,
  srio_target_responder_if.master        m_axis_tresp,
  output logic                           o_db_valid,
  output logic [15:0]                    o_db_info,
  output logic                           o_msg_valid,
  output logic [5:0]                     o_msg_beats,
  output logic                           o_err_unsup
);

  localparam int DEPTH = 2 ** MEM_AW;

  typedef enum logic [2:0] {S_IDLE, S_WDATA, S_MDATA, S_DROP, S_RHDR, S_RDATA} state_t;
  typedef enum logic [2:0] {
    K_NWRITE, K_NWRITE_R, K_SWRITE, K_NREAD, K_DOORBELL, K_MESSAGE, K_UNSUP
  } kind_t;

  function automatic kind_t decode(input logic [3:0] ftype, input logic [3:0] ttype);
    kind_t k;
    k = K_UNSUP;
    case (ftype)
      4'h5:    k = (ttype == 4'h4) ? K_NWRITE : (ttype == 4'h5) ? K_NWRITE_R : K_UNSUP;
      4'h6:    k = K_SWRITE;
      4'h2:    k = (ttype == 4'h4) ? K_NREAD : K_UNSUP;
      4'hA:    k = K_DOORBELL;
      4'hB:    k = K_MESSAGE;
      default: k = K_UNSUP;
    endcase
    return k;
  endfunction

  state_t              state_q;
  kind_t               kind_q;
  logic [7:0]          tid_q;
  logic [1:0]          prio_q;
  logic                crf_q;
  logic [4:0]          last_idx_q;   // index of the final payload word, SIZE[7:3]
  logic [MEM_AW-1:0]   base_q;
  logic [31:0]         tuser_q;
  logic [5:0]          cnt_q;

  logic                treq_ready_q;
  logic                resp_valid_q;
  logic                resp_last_q;
  logic [63:0]         resp_data_q;
  logic [7:0]          resp_keep_q;
  logic [31:0]         resp_user_q;

  logic [63:0]         mem [DEPTH];
  logic [63:0]         mem_q;

  logic                treq_hs;
  logic                tresp_hs;
  kind_t               hdr_kind;
  logic                wr_en;
  logic [MEM_AW-1:0]   wr_addr;
  logic [MEM_AW-1:0]   rd_addr;
  logic [1:0]          prio_inc;
  logic [3:0]          resp_ttype;
  logic [63:0]         resp_hdr;

  assign treq_hs  = s_axis_treq.tvalid & treq_ready_q;
  assign tresp_hs = resp_valid_q & m_axis_tresp.tready;
  assign hdr_kind = decode(s_axis_treq.tdata[55:52], s_axis_treq.tdata[51:48]);

  assign wr_en   = (state_q == S_WDATA) && treq_hs && (cnt_q <= {1'b0, last_idx_q});
  assign wr_addr = base_q + MEM_AW'(cnt_q);
  // Read one word ahead: a data handshake advances the address in the same cycle,
  // so mem_q always holds the next beat to load and beats stay back-to-back.
  assign rd_addr = base_q + MEM_AW'(cnt_q) + MEM_AW'(tresp_hs);

  assign prio_inc   = (prio_q == 2'd3) ? 2'd3 : prio_q + 2'd1;
  assign resp_ttype = (kind_q == K_NREAD) ? 4'h8 : (kind_q == K_MESSAGE) ? 4'h1 : 4'h0;
  assign resp_hdr   = {tid_q, 4'hD, resp_ttype, 1'b0, prio_inc, crf_q, 8'd0, 36'd0};

  // NOTE: the RAM has no reset; its contents are undefined until written.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (s_axis_treq.tkeep[b]) mem[wr_addr][b*8 +: 8] <= s_axis_treq.tdata[b*8 +: 8];
      end
    end
    mem_q <= mem[rd_addr];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      kind_q       <= K_UNSUP;
      tid_q        <= '0;
      prio_q       <= '0;
      crf_q        <= 1'b0;
      last_idx_q   <= '0;
      base_q       <= '0;
      tuser_q      <= '0;
      cnt_q        <= '0;
      treq_ready_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_last_q  <= 1'b0;
      resp_data_q  <= '0;
      resp_keep_q  <= '0;
      resp_user_q  <= '0;
      o_db_valid   <= 1'b0;
      o_db_info    <= '0;
      o_msg_valid  <= 1'b0;
      o_msg_beats  <= '0;
      o_err_unsup  <= 1'b0;
    end else begin
      // NOTE: defaults first, later non-blocking assignments in the same cycle win.
      o_db_valid  <= 1'b0;
      o_msg_valid <= 1'b0;
      o_err_unsup <= 1'b0;
      case (state_q)
        S_IDLE: begin
          treq_ready_q <= 1'b1;
          if (treq_hs) begin
            tid_q      <= s_axis_treq.tdata[63:56];
            prio_q     <= s_axis_treq.tdata[46:45];
            crf_q      <= s_axis_treq.tdata[44];
            last_idx_q <= s_axis_treq.tdata[43:39];
            base_q     <= s_axis_treq.tdata[MEM_AW+2:3];
            tuser_q    <= s_axis_treq.tuser;
            kind_q     <= hdr_kind;
            cnt_q      <= '0;
            case (hdr_kind)
              K_NWRITE, K_SWRITE: if (!s_axis_treq.tlast) state_q <= S_WDATA;
              K_NWRITE_R: begin
                if (s_axis_treq.tlast) begin
                  state_q      <= S_RHDR;
                  treq_ready_q <= 1'b0;
                end else begin
                  state_q <= S_WDATA;
                end
              end
              K_MESSAGE: begin
                if (s_axis_treq.tlast) begin
                  o_msg_valid  <= 1'b1;
                  o_msg_beats  <= '0;
                  state_q      <= S_RHDR;
                  treq_ready_q <= 1'b0;
                end else begin
                  state_q <= S_MDATA;
                end
              end
              K_NREAD, K_DOORBELL: begin
                if (hdr_kind == K_DOORBELL) begin
                  o_db_valid <= 1'b1;
                  o_db_info  <= s_axis_treq.tdata[15:0];
                end
                state_q      <= S_RHDR;
                treq_ready_q <= 1'b0;
              end
              default: begin
                o_err_unsup <= 1'b1;
                if (!s_axis_treq.tlast) state_q <= S_DROP;
              end
            endcase
          end
        end
        S_WDATA: begin
          if (treq_hs) begin
            if (cnt_q <= {1'b0, last_idx_q}) cnt_q <= cnt_q + 6'd1;
            if (s_axis_treq.tlast) begin
              if (kind_q == K_NWRITE_R) begin
                state_q      <= S_RHDR;
                treq_ready_q <= 1'b0;
                cnt_q        <= '0;
              end else begin
                state_q <= S_IDLE;
              end
            end
          end
        end
        S_MDATA: begin
          if (treq_hs) begin
            cnt_q <= cnt_q + 6'd1;
            if (s_axis_treq.tlast) begin
              o_msg_valid  <= 1'b1;
              o_msg_beats  <= cnt_q + 6'd1;
              state_q      <= S_RHDR;
              treq_ready_q <= 1'b0;
              cnt_q        <= '0;
            end
          end
        end
        S_DROP: begin
          if (treq_hs && s_axis_treq.tlast) state_q <= S_IDLE;
        end
        S_RHDR: begin
          if (!resp_valid_q) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= resp_hdr;
            resp_last_q  <= (kind_q != K_NREAD);
            resp_keep_q  <= 8'hFF;
            resp_user_q  <= {tuser_q[15:0], tuser_q[31:16]};
          end else if (tresp_hs) begin
            if (kind_q == K_NREAD) begin
              state_q     <= S_RDATA;
              resp_data_q <= mem_q;
              resp_last_q <= (last_idx_q == 5'd0);
              cnt_q       <= 6'd1;
            end else begin
              state_q      <= S_IDLE;
              resp_valid_q <= 1'b0;
              resp_last_q  <= 1'b0;
              treq_ready_q <= 1'b1;
            end
          end
        end
        S_RDATA: begin
          if (tresp_hs) begin
            if (resp_last_q) begin
              state_q      <= S_IDLE;
              resp_valid_q <= 1'b0;
              resp_last_q  <= 1'b0;
              treq_ready_q <= 1'b1;
            end else begin
              resp_data_q <= mem_q;
              resp_last_q <= (cnt_q == {1'b0, last_idx_q});
              cnt_q       <= cnt_q + 6'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign s_axis_treq.tready  = treq_ready_q;
  assign m_axis_tresp.tvalid = resp_valid_q;
  assign m_axis_tresp.tlast  = resp_last_q;
  assign m_axis_tresp.tdata  = resp_data_q;
  assign m_axis_tresp.tkeep  = resp_keep_q;
  assign m_axis_tresp.tuser  = resp_user_q;

endmodule

// File: tb/tb_srio_target_responder.sv
// Directed bench for srio_target_responder: writes, reads, doorbell, message,
// unsupported drop and reset in the middle of a read response.
module tb_srio_target_responder;

  logic        i_clk;
  logic        i_rst;
  logic        o_db_valid;
  logic [15:0] o_db_info;
  logic        o_msg_valid;
  logic [5:0]  o_msg_beats;
  logic        o_err_unsup;

  srio_target_responder_if treq ();
  srio_target_responder_if tresp ();

  srio_target_responder #(.MEM_AW(6)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .s_axis_treq  (treq),
    .m_axis_tresp (tresp),
    .o_db_valid   (o_db_valid),
    .o_db_info    (o_db_info),
    .o_msg_valid  (o_msg_valid),
    .o_msg_beats  (o_msg_beats),
    .o_err_unsup  (o_err_unsup)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_mem [64];
  logic [63:0] pay_d [64];
  logic [7:0]  pay_k [64];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] hdr(input logic [7:0] tid, input logic [3:0] ft,
                                      input logic [3:0] tt, input logic [1:0] pr,
                                      input logic cr, input logic [7:0] sz,
                                      input logic [33:0] ad);
    return {tid, ft, tt, 1'b0, pr, cr, sz, 2'b00, ad};
  endfunction

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic put(input logic [63:0] d, input logic [7:0] k, input logic l,
                     input logic [31:0] u);
    int n = 0;
    treq.tvalid = 1'b1; treq.tdata = d; treq.tkeep = k; treq.tlast = l; treq.tuser = u;
    while (!treq.tready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 200) chk("put_timeout", treq.tready, 1'b1);
    @(negedge i_clk);
    treq.tvalid = 1'b0;
    treq.tlast  = 1'b0;
  endtask

  // n counts falling edges since the triggering handshake (1 = immediately present).
  task automatic get_resp(output logic [63:0] d, output logic l, output logic [31:0] u,
                          output logic [7:0] kp, output int n);
    n = 1;
    while (!tresp.tvalid && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 200) chk("resp_timeout", tresp.tvalid, 1'b1);
    d = tresp.tdata; l = tresp.tlast; u = tresp.tuser; kp = tresp.tkeep;
    @(negedge i_clk);
  endtask

  task automatic wr_pkt(input logic [3:0] ft, input logic [3:0] tt, input logic [7:0] tid,
                        input logic [1:0] pr, input logic cr, input logic [7:0] sz,
                        input int word, input int nbeats, input logic [31:0] u);
    put(hdr(tid, ft, tt, pr, cr, sz, 34'(word * 8)), 8'hFF, nbeats == 0, u);
    for (int k = 0; k < nbeats; k++) begin
      put(pay_d[k], pay_k[k], k == nbeats - 1, u);
      if (k <= int'(sz >> 3)) begin
        for (int b = 0; b < 8; b++)
          if (pay_k[k][b]) exp_mem[(word + k) % 64][b*8 +: 8] = pay_d[k][b*8 +: 8];
      end
    end
  endtask

  task automatic no_resp(input string tag);
    logic seen = 1'b0;
    repeat (6) begin
      if (tresp.tvalid) seen = 1'b1;
      @(negedge i_clk);
    end
    chk(tag, seen, 1'b0);
  endtask

  task automatic read_check(input logic [7:0] tid, input logic [7:0] sz, input int word,
                            input logic [31:0] u);
    logic [63:0] d; logic l; logic [31:0] ru; logic [7:0] kp; int n; int nb;
    logic busy = 1'b0;
    put(hdr(tid, 4'h2, 4'h4, 2'd0, 1'b0, sz, 34'(word * 8)), 8'hFF, 1'b1, u);
    get_resp(d, l, ru, kp, n);
    chk("rd_latency", n, 2);
    chk("rd_hdr", d, {tid, 4'hD, 4'h8, 1'b0, 2'd1, 1'b0, 44'd0});
    chk("rd_hdr_last", l, 1'b0);
    chk("rd_user", ru, {u[15:0], u[31:16]});
    chk("rd_keep", kp, 8'hFF);
    nb = int'(sz >> 3) + 1;
    for (int k = 0; k < nb; k++) begin
      if (treq.tready) busy = 1'b1;
      get_resp(d, l, ru, kp, n);
      chk($sformatf("rd_data%0d", k), d, exp_mem[(word + k) % 64]);
      chk($sformatf("rd_last%0d", k), l, k == nb - 1);
      chk($sformatf("rd_b2b%0d", k), n, 1);
    end
    chk("rd_treq_blocked", busy, 1'b0);
    chk("rd_valid_drop", tresp.tvalid, 1'b0);
  endtask

  initial begin
    logic [63:0] d, prev_d; logic l, prev_l, prev_stall, busy;
    logic [31:0] ru; logic [7:0] kp; int n, nb;

    i_rst = 1'b1;
    treq.tvalid = 1'b0; treq.tlast = 1'b0; treq.tdata = '0; treq.tkeep = '0; treq.tuser = '0;
    tresp.tready = 1'b1;
    #12;
    chk("rst_treq_ready", treq.tready, 1'b0);
    chk("rst_tvalid", tresp.tvalid, 1'b0);
    chk("rst_tlast", tresp.tlast, 1'b0);
    chk("rst_tdata", tresp.tdata, 64'd0);
    chk("rst_tkeep", tresp.tkeep, 8'd0);
    chk("rst_tuser", tresp.tuser, 32'd0);
    chk("rst_db_valid", o_db_valid, 1'b0);
    chk("rst_db_info", o_db_info, 16'd0);
    chk("rst_msg_valid", o_msg_valid, 1'b0);
    chk("rst_msg_beats", o_msg_beats, 6'd0);
    chk("rst_err", o_err_unsup, 1'b0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // NWRITE 256 bytes at word 0, then read them back.
    for (int k = 0; k < 32; k++) begin
      pay_d[k] = {4{16'(k)}};
      pay_k[k] = 8'hFF;
    end
    wr_pkt(4'h5, 4'h4, 8'h01, 2'd0, 1'b0, 8'd255, 0, 32, 32'h0005_0007);
    no_resp("nwrite_no_resp");
    read_check(8'h33, 8'd255, 0, 32'h0005_0007);

    // NREAD with the response stream stalling every other cycle.
    put(hdr(8'h34, 4'h2, 4'h4, 2'd0, 1'b0, 8'd255, 34'd0), 8'hFF, 1'b1, 32'h0);
    nb = 0; prev_stall = 1'b0; busy = 1'b0; prev_d = '0; prev_l = 1'b0;
    for (int c = 0; c < 300 && nb < 33; c++) begin
      tresp.tready = (c % 2 == 0);
      if (treq.tready) busy = 1'b1;
      if (tresp.tvalid) begin
        if (prev_stall) begin
          chk("stall_data_hold", tresp.tdata, prev_d);
          chk("stall_last_hold", tresp.tlast, prev_l);
        end
        if (tresp.tready) begin
          if (nb == 0) chk("tog_hdr", tresp.tdata, {8'h34, 4'hD, 4'h8, 1'b0, 2'd1, 1'b0, 44'd0});
          else begin
            chk($sformatf("tog_data%0d", nb - 1), tresp.tdata, exp_mem[nb - 1]);
            chk($sformatf("tog_last%0d", nb - 1), tresp.tlast, nb == 32);
          end
          nb++;
        end
        prev_stall = !tresp.tready; prev_d = tresp.tdata; prev_l = tresp.tlast;
      end
      @(negedge i_clk);
    end
    tresp.tready = 1'b1;
    chk("tog_beat_count", nb, 33);
    chk("tog_treq_blocked", busy, 1'b0);

    // DOORBELL
    put(hdr(8'h12, 4'hA, 4'h0, 2'd1, 1'b0, 8'd0, 34'h0A5C3), 8'hFF, 1'b1, 32'h0001_0002);
    chk("db_pulse", o_db_valid, 1'b1);
    chk("db_info", o_db_info, 16'hA5C3);
    get_resp(d, l, ru, kp, n);
    chk("db_latency", n, 2);
    chk("db_resp_hdr", d, {8'h12, 4'hD, 4'h0, 1'b0, 2'd2, 1'b0, 44'd0});
    chk("db_resp_last", l, 1'b1);
    chk("db_resp_user", ru, 32'h0002_0001);
    chk("db_pulse_end", o_db_valid, 1'b0);
    chk("db_info_hold", o_db_info, 16'hA5C3);
    chk("db_valid_drop", tresp.tvalid, 1'b0);

    // NWRITE_R across the top of the RAM, partial byte enables on the wrapped word.
    pay_d[0] = 64'hDEAD_BEEF_0000_0063; pay_k[0] = 8'hFF;
    pay_d[1] = 64'h0123_4567_89AB_CDEF; pay_k[1] = 8'h0F;
    wr_pkt(4'h5, 4'h5, 8'h44, 2'd3, 1'b1, 8'd15, 63, 2, 32'h0000_00AA);
    get_resp(d, l, ru, kp, n);
    chk("nwr_r_latency", n, 2);
    chk("nwr_r_hdr", d, {8'h44, 4'hD, 4'h0, 1'b0, 2'd3, 1'b1, 44'd0});
    chk("nwr_r_last", l, 1'b1);
    chk("nwr_r_user", ru, 32'h00AA_0000);
    read_check(8'h45, 8'd15, 63, 32'h0000_0001);
    chk("wrap_word0_model", exp_mem[0], 64'h0000_0000_89AB_CDEF);

    // SWRITE with one beat more than SIZE covers; the extra beat must not land.
    pay_d[0] = 64'h5555_AAAA_5555_AAAA; pay_k[0] = 8'hFF;
    pay_d[1] = 64'hFFFF_FFFF_FFFF_FFFF; pay_k[1] = 8'hFF;
    wr_pkt(4'h6, 4'h0, 8'h46, 2'd0, 1'b0, 8'd7, 5, 2, 32'h0);
    no_resp("swrite_no_resp");
    read_check(8'h47, 8'd15, 5, 32'h0);

    // MESSAGE of 8 beats, then an unsupported FTYPE 7 packet.
    put(hdr(8'h55, 4'hB, 4'h0, 2'd0, 1'b0, 8'd63, 34'd0), 8'hFF, 1'b0, 32'h0003_0004);
    for (int k = 0; k < 8; k++) put(64'(k), 8'hFF, k == 7, 32'h0003_0004);
    chk("msg_pulse", o_msg_valid, 1'b1);
    chk("msg_beats", o_msg_beats, 6'd8);
    get_resp(d, l, ru, kp, n);
    chk("msg_latency", n, 2);
    chk("msg_resp_hdr", d, {8'h55, 4'hD, 4'h1, 1'b0, 2'd1, 1'b0, 44'd0});
    chk("msg_resp_last", l, 1'b1);
    chk("msg_resp_user", ru, 32'h0004_0003);
    chk("msg_pulse_end", o_msg_valid, 1'b0);
    put(hdr(8'h66, 4'h7, 4'h0, 2'd0, 1'b0, 8'd23, 34'd0), 8'hFF, 1'b0, 32'h0);
    chk("unsup_pulse", o_err_unsup, 1'b1);
    put(64'h1, 8'hFF, 1'b0, 32'h0);
    chk("unsup_pulse_end", o_err_unsup, 1'b0);
    put(64'h2, 8'hFF, 1'b0, 32'h0);
    put(64'h3, 8'hFF, 1'b1, 32'h0);
    no_resp("unsup_no_resp");

    // Reset while read data beat 10 is on the bus.
    put(hdr(8'h77, 4'h2, 4'h4, 2'd0, 1'b0, 8'd255, 34'd0), 8'hFF, 1'b1, 32'h0);
    for (int k = 0; k < 11; k++) get_resp(d, l, ru, kp, n);
    chk("pre_rst_valid", tresp.tvalid, 1'b1);
    chk("pre_rst_beat10", tresp.tdata, exp_mem[10]);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_valid", tresp.tvalid, 1'b0);
    chk("mid_rst_last", tresp.tlast, 1'b0);
    chk("mid_rst_data", tresp.tdata, 64'd0);
    chk("mid_rst_treq_ready", treq.tready, 1'b0);
    @(negedge i_clk);
    i_rst = 1'b0;
    read_check(8'h78, 8'd255, 0, 32'h0009_0008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
